// File: rtl/demux_pkg.sv
// Shared constants for the four-channel demultiplexer: channel count, index width,
// channel identifiers and accept-counter width.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 8;

  localparam logic [CH_W-1:0] CH_A = 2'd0;
  localparam logic [CH_W-1:0] CH_B = 2'd1;
  localparam logic [CH_W-1:0] CH_C = 2'd2;
  localparam logic [CH_W-1:0] CH_D = 2'd3;

  // Round-robin successor; the 2-bit index wraps D -> A naturally.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/nbit_demux_if.sv
// Bundle of the demultiplexer's producer/consumer signals, with a master view
// (traffic source and sink) and a slave view (the demultiplexer itself).
interface nbit_demux_if #(
  parameter int N = 8
);
  import demux_pkg::*;

  logic                    auto_mode;
  logic [N-1:0]            in_data;
  logic [CH_W-1:0]         in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*N-1:0]     out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [CH_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        acc_cnt;

  modport master (
    output auto_mode, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr, acc_cnt
  );

  modport slave (
    input  auto_mode, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, rr_ptr, acc_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry output buffer for a single channel. A load wins over a delivery in the
// same cycle, so a simultaneous drain-and-refill keeps valid high with the new word.
module demux_slot #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         deliver,
  input  logic [N-1:0] load_data,
  output logic [N-1:0] data,
  output logic         valid
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (deliver) begin
      // Data is deliberately left in place after delivery.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/nbit_demux.sv
// Routes N-bit words into one of four single-entry channel buffers, selected either
// by in_sel or by an internal round-robin pointer, and counts accepted words.
module nbit_demux
  import demux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto_mode,
  input  logic [N-1:0]        in_data,
  input  logic [CH_W-1:0]     in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_CH*N-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [CH_W-1:0]     rr_ptr,
  output logic [CNT_W-1:0]    acc_cnt
);

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CH_W-1:0]   target;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] deliver;

  // A channel can take a word if it is empty or is being drained this cycle.
  always_comb begin
    target   = auto_mode ? rr_ptr_q : in_sel;
    in_ready = ~out_valid[target] | out_ready[target];
    accept   = in_valid & in_ready;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    acc_cnt_d = acc_cnt_q;
    if (accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
      if (auto_mode) begin
        rr_ptr_d = next_ch(rr_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= CH_A;
      acc_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign load[gi]    = accept & (target == CH_W'(gi));
      assign deliver[gi] = out_valid[gi] & out_ready[gi];

      demux_slot #(.N(N)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load[gi]),
        .deliver   (deliver[gi]),
        .load_data (in_data),
        .data      (out_data[gi*N +: N]),
        .valid     (out_valid[gi])
      );
    end
  endgenerate

  assign rr_ptr  = rr_ptr_q;
  assign acc_cnt = acc_cnt_q;

endmodule

// File: doc/nbit_demux.md
NBIT_DEMUX -- requirements
Module: nbit_demux

Interface
REQ-001 SHALL have parameter: N, 8, data word width in bits (N >= 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: auto_mode  input  1  1 = round-robin routing; 0 = routing by in_sel.
REQ-005 SHALL have port: in_data  input  N  word to route.
REQ-006 SHALL have port: in_sel  input  2  target channel when auto_mode=0 (0=A, 1=B, 2=C, 3=D).
REQ-007 SHALL have port: in_valid  input  1  in_data/in_sel valid.
REQ-008 SHALL have port: in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have port: out_data  output  4*N  channel words; slice k = bits [k*N +: N], k=0..3 (A..D).
REQ-010 SHALL have port: out_valid  output  4  per-channel word present.
REQ-011 SHALL have port: out_ready  input  4  per-channel consumer ready.
REQ-012 SHALL have port: rr_ptr  output  2  current round-robin channel.
REQ-013 SHALL have port: acc_cnt  output  8  count of accepted input words.

Function
REQ-014 SHALL define target t = auto_mode ? rr_ptr : in_sel.
REQ-015 SHALL drive in_ready combinationally = ~out_valid[t] | out_ready[t].
REQ-016 SHALL accept a word when in_valid & in_ready; no other condition accepts.
REQ-017 SHALL hold one N-bit entry per channel; on accept, out_data slice t = in_data and out_valid[t] = 1 on the next edge (latency 1 cycle).
REQ-018 SHALL deliver channel k when out_valid[k] & out_ready[k]; out_valid[k] clears next edge unless channel k is refilled in the same cycle.
REQ-019 SHALL, on simultaneous deliver and refill of the same channel, load the new word with out_valid[k] staying 1 (no bubble, no loss).
REQ-020 SHALL hold out_data slice k stable while out_valid[k] & ~out_ready[k].
REQ-021 SHALL leave non-target channels unaffected by an accept; channels drain independently and concurrently.
REQ-022 SHALL advance rr_ptr by 1 on each accept while auto_mode=1, wrapping 3 -> 0; rr_ptr holds otherwise.
REQ-023 SHALL retain rr_ptr across auto_mode toggles; the first auto-mode accept targets the retained value.
REQ-024 SHALL ignore in_sel when auto_mode=1.
REQ-025 SHALL increment acc_cnt on every accept, wrapping 255 -> 0.
REQ-026 SHALL ignore in_data/in_sel when in_valid=0; no state change.
REQ-027 SHALL keep out_data slice k unchanged after delivery until next refill (value not cleared).

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set out_valid=0, out_data=0, rr_ptr=0, acc_cnt=0; rst has priority over accept and deliver in that cycle.
REQ-029 SHALL discard buffered words on reset mid-operation; in_ready = 1 in the cycle after reset deasserts.
REQ-030 SHALL not change state asynchronously on rst.

Structure
REQ-031 SHALL place channel-count constant (4), channel index width (2), channel index constants CH_A..CH_D and counter width (8) in shared package demux_pkg.
REQ-032 SHALL implement the one-entry per-channel buffer as sub-module demux_slot (load, deliver, data, valid), instantiated four times.

Verification
REQ-033 SHALL cover: auto_mode=0, out_ready=4'b1111, send 8'h0F/F0/55/AA with in_sel 0/1/2/3 -> slices A..D = 0F,F0,55,AA one cycle after each accept; acc_cnt=4.
REQ-034 SHALL cover: auto_mode=1, send 8'hFF,00,A5,5A,11 -> A=FF, B=00, C=A5, D=5A, then A=11; rr_ptr sequence 0,1,2,3,0,1.
REQ-035 SHALL cover: out_ready[0]=0, in_sel=0, send 8'h0F then 8'h33 -> second word stalls (in_ready=0), A holds 0F; raising out_ready[0] loads 33 with no bubble.
REQ-036 SHALL cover: channel B full and stalled, send 8'h55 to C -> accepted, B unchanged.
REQ-037 SHALL cover: 256 accepts -> acc_cnt wraps to 0; assert rst with all four channels valid -> next cycle out_valid=0, out_data=0, rr_ptr=0, acc_cnt=0.
REQ-038 SHALL cover: toggle auto_mode after 2 auto accepts, 1 manual to D, back to auto -> next auto word routed to C (rr_ptr=2).
